// File: rtl/alu_uart_ctrl_if.sv
// Bus bundle between the UART rx/tx + ALU side and the alu_uart_ctrl sequencer.
// The slave modport is the sequencer; the master modport is the surrounding UART/ALU logic.
interface alu_uart_ctrl_if #(
    parameter int unsigned NB_DATA = 8,
    parameter int unsigned NB_OP   = 6
) ();
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_operand1;
    logic [NB_DATA-1:0] o_operand2;
    logic [NB_OP-1:0]   o_opcode;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_overrun;
    logic               o_timeout;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_operand1, o_operand2, o_opcode, o_tx_data,
        output o_tx_start, o_busy, o_overrun, o_timeout
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_operand1, o_operand2, o_opcode, o_tx_data,
        input  o_tx_start, o_busy, o_overrun, o_timeout
    );
endinterface

// File: rtl/alu_uart_ctrl.sv
// Collects operand1, operand2, opcode bytes from the UART, runs the ALU and sends the result back.
// Define ALU_CTRL_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module alu_uart_ctrl #(
    parameter int unsigned NB_DATA        = 8,
    parameter int unsigned NB_OP          = 6,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic            clk,
    input logic            i_reset,
    alu_uart_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StWaitOp1, StWaitOp2, StWaitOpc, StExec, StSend, StWaitTx
    } state_e;

    state_e             state_q, state_d;
    logic [NB_DATA-1:0] operand1_q, operand1_d;
    logic [NB_DATA-1:0] operand2_q, operand2_d;
    logic [NB_OP-1:0]   opcode_q, opcode_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               timeout_hit;

`ifdef ALU_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter is held at zero outside the two mid-frame states, which covers the entry clear.
    always_comb begin
        cnt_d       = '0;
        timeout_hit = 1'b0;
        if ((state_q == StWaitOp2 || state_q == StWaitOpc) && !bus.i_rx_done) begin
            if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= StWaitOp1;
            operand1_q <= '0;
            operand2_q <= '0;
            opcode_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            operand1_q <= operand1_d;
            operand2_q <= operand2_d;
            opcode_q   <= opcode_d;
            tx_data_q  <= tx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        operand1_d = operand1_q;
        operand2_d = operand2_q;
        opcode_d   = opcode_q;
        tx_data_d  = tx_data_q;
        unique case (state_q)
            StWaitOp1: begin
                if (bus.i_rx_done) begin
                    operand1_d = bus.i_rx_data;
                    state_d    = StWaitOp2;
                end
            end
            StWaitOp2: begin
                if (bus.i_rx_done) begin
                    operand2_d = bus.i_rx_data;
                    state_d    = StWaitOpc;
                end else if (timeout_hit) begin
                    state_d = StWaitOp1;
                end
            end
            StWaitOpc: begin
                if (bus.i_rx_done) begin
                    opcode_d = bus.i_rx_data[NB_OP-1:0];
                    state_d  = StExec;
                end else if (timeout_hit) begin
                    state_d = StWaitOp1;
                end
            end
            // One cycle for the ALU to settle on the freshly registered inputs.
            StExec: begin
                tx_data_d = bus.i_alu_result;
                state_d   = StSend;
            end
            StSend: state_d = StWaitTx;
            StWaitTx: begin
                if (bus.i_tx_done) begin
                    state_d = StWaitOp1;
                end
            end
            default: state_d = StWaitOp1;
        endcase
    end

    always_comb begin
        bus.o_tx_start = (state_q == StSend);
        bus.o_busy     = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);
        // Any byte arriving while busy is dropped, including one coincident with i_tx_done.
        bus.o_overrun  = bus.o_busy && bus.i_rx_done;
        bus.o_timeout  = timeout_hit;
    end

    assign bus.o_operand1 = operand1_q;
    assign bus.o_operand2 = operand2_q;
    assign bus.o_opcode   = opcode_q;
    assign bus.o_tx_data  = tx_data_q;

endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Byte-stream sequencer that feeds the combinational ALU from a UART receiver and returns the ALU result to a UART transmitter.
- Collects three bytes in order: operand1, operand2, opcode. Drives the ALU, latches the result, then hands it to the transmitter.
- Sits between the UART rx/tx modules and the ALU in the UART-based top level. It replaces the switch/button interface.

Parameters:
NB_DATA, 8, width of UART bytes, operands and result
NB_OP, 6, opcode width; the opcode is taken from the low NB_OP bits of the third byte
TIMEOUT_CYCLES, 50_000_000, inter-byte timeout in clk cycles (used only with ALU_CTRL_TIMEOUT_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
i_reset  input  1  asynchronous, active-low reset
i_rx_data  input  NB_DATA  received byte, valid when i_rx_done=1
i_rx_done  input  1  single-cycle pulse: new byte on i_rx_data
i_alu_result  input  NB_DATA  ALU result (combinational from o_operand1/2, o_opcode)
i_tx_done  input  1  single-cycle pulse: transmitter finished the byte
o_operand1  output  NB_DATA  registered operand1 to ALU
o_operand2  output  NB_DATA  registered operand2 to ALU
o_opcode  output  NB_OP  registered opcode to ALU
o_tx_data  output  NB_DATA  latched result to transmitter
o_tx_start  output  1  single-cycle pulse requesting transmission
o_busy  output  1  high from opcode capture until i_tx_done
o_overrun  output  1  single-cycle pulse: byte received while busy and dropped
o_timeout  output  1  single-cycle pulse: partial frame aborted (only with ALU_CTRL_TIMEOUT_EN, else tied 0)

Behaviour:
- Reset (i_reset=0, async): state=WAIT_OP1. All outputs are 0. Reset mid-frame or mid-transmission discards all progress.
- States: WAIT_OP1, WAIT_OP2, WAIT_OPC, EXEC, SEND, WAIT_TX.
- WAIT_OP1: on i_rx_done, o_operand1<=i_rx_data and go to WAIT_OP2.
- WAIT_OP2: on i_rx_done, o_operand2<=i_rx_data and go to WAIT_OPC.
- WAIT_OPC: on i_rx_done, o_opcode<=i_rx_data[NB_OP-1:0] and go to EXEC. Upper bits of the byte are ignored.
- EXEC: exactly one cycle, so the ALU settles on the new registered inputs. Then o_tx_data<=i_alu_result and go to SEND.
- SEND: o_tx_start=1 for exactly one cycle, then go to WAIT_TX.
- WAIT_TX: hold until i_tx_done, then go to WAIT_OP1.
- Latency: o_tx_start asserts 2 cycles after the clock edge that samples the opcode's i_rx_done.
- o_busy=1 in EXEC, SEND and WAIT_TX; 0 otherwise.
- i_rx_done in EXEC, SEND or WAIT_TX: the byte is dropped, o_overrun pulses for 1 cycle, and state is unaffected.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: return to WAIT_OP1, the byte is dropped, o_overrun pulses.
- i_tx_done outside WAIT_TX is ignored.
- Operand and opcode registers hold their values after the frame, so the ALU output stays stable until the next byte overwrites them.
- Data values are pass-through. The block does no arithmetic; signedness is the ALU's concern.

Optional Feature:
- Macro ALU_CTRL_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in WAIT_OP2 and WAIT_OPC.
  - The counter clears on every i_rx_done and on entry to those states.
  - On reaching TIMEOUT_CYCLES-1 without a byte: go to WAIT_OP1, pulse o_timeout for 1 cycle, leave operand/opcode registers unchanged.
  - A byte arriving on the same cycle as the timeout wins: it is accepted and there is no timeout.
- Undefined: no counter; o_timeout is constant 0; a partial frame waits indefinitely.

Test Plan:
- Reset then bytes 0x05, 0x03, 0x20 (ADD) with ALU model -> o_operand1=0x05, o_operand2=0x03, o_opcode=0x20; o_tx_start pulses once 2 cycles after the third rx_done; o_tx_data=0x08.
- Bytes 0x80, 0x01, 0xE2 -> o_opcode=0x22 (upper bits dropped); o_tx_data equals the model's result for 0x22.
- Byte 0x11 during WAIT_TX -> o_overrun single pulse, byte dropped; after i_tx_done the next frame 0x01, 0x01, 0x20 yields 0x02.
- i_reset low during WAIT_OPC after two bytes -> all outputs 0, state WAIT_OP1; a following full frame is processed correctly.
- Two back-to-back frames, each i_tx_done 10 cycles after o_tx_start -> two o_tx_start pulses, o_busy low between frames.
- With ALU_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 0x07, then idle 16 cycles -> o_timeout pulse and return to WAIT_OP1; next bytes 0x02, 0x02, 0x20 give 0x04.
